reg_cmd_parser: RTL and testbench

//  Byte-stream command parser feeding the waveform generator register file.

---
 rtl/reg_cmd_parser.sv | 129 ++++++++++++
 tb/tb_reg_cmd_parser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_parser.sv
// Assembles 4-byte [SYNC, ADDR, DATA, CSUM] write frames from a UART byte stream
// and drives a register-file write port, reporting rejected frames with a code and count.
//
//   state  | meaning
//   S_SYNC | idle, hunting for SYNC_BYTE; other bytes dropped
//   S_ADDR | expecting the address byte
//   S_DATA | expecting the data byte
//   S_CSUM | expecting the checksum byte (addr ^ data)
module reg_cmd_parser #(
  parameter logic [7:0]  MAX_ADDR    = 8'd8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] addr_o,
  output logic [7:0] data_o,
  output logic       wr_en_o,
  output logic       err_valid_o,
  output logic [1:0] err_code_o,
  output logic [7:0] err_cnt_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {S_SYNC, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout;

  // An arriving byte always beats an expiring timer.
  assign timeout = (state_q != S_SYNC) && !rx_valid_i &&
                   (tmo_cnt_q == TIMEOUT_CYC - 16'd1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;

    if (rx_valid_i || state_q == S_SYNC || timeout) tmo_cnt_d = 16'd0;
    else                                             tmo_cnt_d = tmo_cnt_q + 16'd1;

    case (state_q)
      S_SYNC: if (rx_valid_i && rx_data_i == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR: if (rx_valid_i) begin
        addr_d  = rx_data_i;
        state_d = S_DATA;
      end
      S_DATA: if (rx_valid_i) begin
        data_d  = rx_data_i;
        state_d = S_CSUM;
      end
      S_CSUM: if (rx_valid_i) begin
        state_d = S_SYNC;
        if (rx_data_i != (addr_q ^ data_q)) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'd1;
        end else if (addr_q >= MAX_ADDR) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'd2;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (timeout) begin
      state_d     = S_SYNC;
      err_valid_d = 1'b1;
      err_code_d  = 2'd3;
    end

    if (err_valid_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= 8'd0;
      tmo_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign addr_o      = wr_addr_q;
  assign data_o      = wr_data_q;
  assign wr_en_o     = wr_en_q;
  assign err_valid_o = err_valid_q;
  assign err_code_o  = err_code_q;
  assign err_cnt_o   = err_cnt_q;
  assign busy_o      = (state_q != S_SYNC);

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Bench for reg_cmd_parser: directed scenarios plus random frames, all checked
// every cycle against a frame-level reference model.
module tb_reg_cmd_parser;
  localparam logic [7:0]  MAXA = 8'd8;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [15:0] TMO  = 16'd20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data_i = 8'd0;
  logic       rx_valid_i = 1'b0;
  logic [7:0] addr_o, data_o, err_cnt_o;
  logic       wr_en_o, err_valid_o, busy_o;
  logic [1:0] err_code_o;

  reg_cmd_parser #(.MAX_ADDR(MAXA), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .addr_o(addr_o), .data_o(data_o), .wr_en_o(wr_en_o), .err_valid_o(err_valid_o),
    .err_code_o(err_code_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;

  // reference model: collected frame bytes plus expected output values
  int frame[$];
  int cyc = 0, last_cyc = 0;
  int m_addr = 0, m_data = 0, m_wr = 0, m_errv = 0, m_code = 0, m_cnt = 0, m_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_err(input int code);
    m_errv = 1;
    m_code = code;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_step(input bit v, input int d);
    int a, dd;
    m_wr = 0;
    m_errv = 0;
    cyc++;
    if (v) begin
      last_cyc = cyc;
      if (frame.size() == 0) begin
        if (d == SYNC) frame.push_back(d);
      end else begin
        frame.push_back(d);
        if (frame.size() == 4) begin
          a = frame[1];
          dd = frame[2];
          if (d != (a ^ dd)) model_err(1);
          else if (a >= MAXA) model_err(2);
          else begin
            m_wr = 1; m_addr = a; m_data = dd;
          end
          frame.delete();
        end
      end
    end else if (frame.size() != 0 && (cyc - last_cyc) == TMO) begin
      model_err(3);
      frame.delete();
    end
    m_busy = (frame.size() != 0);
  endtask

  task automatic compare_all();
    check("wr_en", wr_en_o, m_wr);
    check("addr", addr_o, m_addr);
    check("data", data_o, m_data);
    check("err_valid", err_valid_o, m_errv);
    check("err_code", err_code_o, m_code);
    check("err_cnt", err_cnt_o, m_cnt);
    check("busy", busy_o, m_busy);
    if (wr_en_o) wr_seen++;
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    rx_valid_i = v;
    rx_data_i  = v ? d : 8'h00;
    model_step(v, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] cs, input int gap);
    send(SYNC, gap); send(a, gap); send(d, gap); send(cs, gap);
  endtask

  task automatic model_reset();
    frame.delete();
    m_addr = 0; m_data = 0; m_wr = 0; m_errv = 0; m_code = 0; m_cnt = 0; m_busy = 0;
  endtask

  task automatic reset_now();
    rx_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    #2;
    compare_all();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic write
    w0 = wr_seen;
    send_frame(8'h03, 8'h5C, 8'h5F, 3);
    check("t1_writes", wr_seen - w0, 1);
    check("t1_addr", addr_o, 8'h03);
    check("t1_data", data_o, 8'h5C);

    // 2: checksum error then good frame
    send_frame(8'h03, 8'h5C, 8'h00, 1);
    check("t2_code", err_code_o, 2'd1);
    check("t2_cnt", err_cnt_o, 8'd1);
    send_frame(8'h01, 8'hFF, 8'hFE, 0);
    step(1'b0, 8'h00);
    check("t2_addr", addr_o, 8'h01);

    // 3: address range boundary
    send_frame(8'h08, 8'h11, 8'h19, 0);
    step(1'b0, 8'h00);
    check("t3_code", err_code_o, 2'd2);
    w0 = wr_seen;
    send_frame(8'h07, 8'h11, 8'h16, 0);
    step(1'b0, 8'h00);
    check("t3_writes", wr_seen - w0, 1);

    // 4: timeout, then a byte exactly at the expiry cycle
    send(SYNC, 0); send(8'h02, 0);
    repeat (TMO + 2) step(1'b0, 8'h00);
    check("t4_code", err_code_o, 2'd3);
    check("t4_busy", busy_o, 1'b0);
    w0 = wr_seen;
    send(SYNC, TMO - 1); send(8'h02, TMO - 1); send(8'h5C, TMO - 1); send(8'h5E, 1);
    check("t4_edge_writes", wr_seen - w0, 1);
    check("t4_edge_code", err_code_o, 2'd3);

    // 5: garbage, SYNC as payload, back-to-back frames
    send(8'h00, 0); send(8'hFF, 0); send(8'h12, 0);
    send_frame(8'h00, SYNC, SYNC, 0);
    step(1'b0, 8'h00);
    check("t5_data", data_o, SYNC);
    w0 = wr_seen;
    send_frame(8'h04, 8'h10, 8'h14, 0);
    send_frame(8'h05, 8'h20, 8'h25, 0);
    step(1'b0, 8'h00);
    check("t5_b2b_writes", wr_seen - w0, 2);

    // 6: saturation, reset mid-frame, recovery
    repeat (300) send_frame(8'h01, 8'h02, 8'h00, 0);
    step(1'b0, 8'h00);
    check("t6_sat", err_cnt_o, 8'hFF);
    send(SYNC, 0); send(8'h04, 0);
    reset_now();
    repeat (3) step(1'b0, 8'h00);
    w0 = wr_seen;
    send_frame(8'h06, 8'h33, 8'h35, 1);
    check("t6_post_rst_writes", wr_seen - w0, 1);

    // random frames with occasional corruption, garbage and near-timeout gaps
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, d, cs;
      int gap, sel;
      a   = 8'($urandom_range(0, 10));
      d   = 8'($urandom);
      cs  = a ^ d;
      sel = $urandom_range(0, 9);
      if (sel == 0) cs = cs ^ 8'($urandom_range(1, 255));
      if (sel == 1) send(8'($urandom_range(0, 160)), 0);
      gap = (sel == 2) ? int'(TMO) - 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
      send(SYNC, $urandom_range(0, 2));
      send(a, gap);
      send(d, $urandom_range(0, 2));
      send(cs, $urandom_range(0, 2));
      if (sel == 3) reset_now();
    end
    repeat (TMO + 2) step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
